// File: rtl/regbank_wb_arbiter.sv
// regbank_wb_arbiter: ALU/MEM write-port arbiter with RAW scoreboard; define REGBANK_WB_BYPASS_EN for commit-cycle forwarding
module regbank_wb_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iss_valid,
  input  logic [3:0]  iss_addr,
  output logic        iss_ready,
  input  logic [3:0]  rd_addr_a,
  input  logic [3:0]  rd_addr_b,
  output logic        hazard,
  input  logic        alu_req,
  input  logic [3:0]  alu_addr,
  input  logic [31:0] alu_data,
  input  logic        alu_high,
  output logic        alu_gnt,
  input  logic        mem_req,
  input  logic [3:0]  mem_addr,
  input  logic [31:0] mem_data,
  output logic        mem_gnt,
`ifdef REGBANK_WB_BYPASS_EN
  output logic        fwd_a_sel,
  output logic        fwd_b_sel,
  output logic [31:0] fwd_data,
`endif
  output logic        wb_we,
  output logic        wb_high,
  output logic [3:0]  wb_addr,
  output logic [31:0] wb_data
);
  logic [1:0]  cnt [16];
  logic [3:0]  starve;
  logic [15:0] inc, dec;
  logic        alu_win, haz_a, haz_b;
  logic [3:0]  win_addr;
  // Grant selection, scoreboard update masks and hazard detection
  always_comb begin
    alu_win   = alu_req && (!mem_req || starve == 4'(STARVE_LIMIT));
    alu_gnt   = alu_win;
    mem_gnt   = mem_req && !alu_win;
    win_addr  = alu_win ? alu_addr : mem_addr;
    dec       = wb_we ? 16'(1) << wb_addr : '0;
    iss_ready = iss_addr == 4'd0 || cnt[iss_addr] != 2'd3 || dec[iss_addr];
    inc       = (iss_valid && iss_ready && iss_addr != 4'd0) ? 16'(1) << iss_addr : '0;
    haz_a     = rd_addr_a != 4'd0 && cnt[rd_addr_a] != 2'd0;
    haz_b     = rd_addr_b != 4'd0 && cnt[rd_addr_b] != 2'd0;
`ifdef REGBANK_WB_BYPASS_EN
    fwd_a_sel = haz_a && wb_we && !wb_high && wb_addr == rd_addr_a && cnt[rd_addr_a] == 2'd1;
    fwd_b_sel = haz_b && wb_we && !wb_high && wb_addr == rd_addr_b && cnt[rd_addr_b] == 2'd1;
    fwd_data  = wb_data;
    hazard    = (haz_a && !fwd_a_sel) || (haz_b && !fwd_b_sel);
`else
    hazard    = haz_a || haz_b;
`endif
  end
  // Starvation counter: counts MEM wins while ALU waits
  always_ff @(posedge clk or posedge reset)
    if (reset) starve <= '0;
    else if (alu_gnt || !alu_req) starve <= '0;
    else if (mem_gnt && starve != 4'(STARVE_LIMIT)) starve <= starve + 4'd1;
  // Registered write port; writes to r0 are swallowed, idle cycles hold addr/data
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wb_we   <= 1'b0;
      wb_high <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      wb_we <= (alu_gnt || mem_gnt) && win_addr != 4'd0;
      if ((alu_gnt || mem_gnt) && win_addr != 4'd0) begin
        wb_addr <= win_addr;
        wb_data <= alu_win ? alu_data : mem_data;
        wb_high <= alu_win && alu_high;
      end
    end
  // Outstanding-write counters; simultaneous issue and commit cancel, underflow ignored
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < 16; i++) cnt[i] <= 2'd0;
    end else begin
      for (int i = 0; i < 16; i++)
        if (inc[i] && !dec[i]) cnt[i] <= cnt[i] + 2'd1;
        else if (dec[i] && !inc[i] && cnt[i] != 2'd0) cnt[i] <= cnt[i] - 2'd1;
    end
endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// tb_regbank_wb_arbiter: table-driven cycle vectors plus async reset sequence
module tb_regbank_wb_arbiter;
`ifdef REGBANK_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic        clk = 0, reset = 1;
  logic        iss_valid = 0, alu_req = 0, alu_high = 0, mem_req = 0;
  logic [3:0]  iss_addr = 0, rd_addr_a = 0, rd_addr_b = 0, alu_addr = 0, mem_addr = 0;
  logic [31:0] alu_data = 0, mem_data = 0;
  logic        iss_ready, hazard, alu_gnt, mem_gnt, wb_we, wb_high;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
`ifdef REGBANK_WB_BYPASS_EN
  logic        fwd_a_sel, fwd_b_sel;
  logic [31:0] fwd_data;
`endif
  int tests = 0, fails = 0;

  regbank_wb_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk(clk), .reset(reset),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .hazard(hazard),
    .alu_req(alu_req), .alu_addr(alu_addr), .alu_data(alu_data), .alu_high(alu_high), .alu_gnt(alu_gnt),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_gnt(mem_gnt),
`ifdef REGBANK_WB_BYPASS_EN
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .fwd_data(fwd_data),
`endif
    .wb_we(wb_we), .wb_high(wb_high), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic iv; logic [3:0] ia, ra, rb;
    logic ar; logic [3:0] aa; logic [31:0] ad; logic ah;
    logic mr; logic [3:0] ma; logic [31:0] md;
    logic ag, mg, ir, hz, we; logic [3:0] wa; logic [31:0] wd; logic wh, fa;
  } vec_t;
  vec_t v[$];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    //          iv ia ra rb  ar aa ad            ah  mr ma md             ag mg ir hz    we wa wd            wh fa
    v.push_back('{0, 0, 5, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,         0, 0, 1, 0,    0, 0, 32'h0,        0, 0});
    v.push_back('{1, 5, 5, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,         0, 0, 1, 0,    0, 0, 32'h0,        0, 0});
    v.push_back('{0, 0, 5, 0, 1, 5, 32'h12345678, 0, 0, 0, 32'h0,         1, 0, 1, 1,    0, 0, 32'h0,        0, 0});
    v.push_back('{0, 0, 5, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,         0, 0, 1, !BYP, 1, 5, 32'h12345678, 0, 1});
    v.push_back('{0, 0, 5, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,         0, 0, 1, 0,    0, 0, 32'h0,        0, 0});
    v.push_back('{0, 0, 0, 0, 1, 1, 32'hA1,       0, 1, 2, 32'hB2,        0, 1, 1, 0,    0, 0, 32'h0,        0, 0});
    v.push_back('{0, 0, 0, 0, 1, 1, 32'hA1,       0, 1, 2, 32'hB2,        0, 1, 1, 0,    1, 2, 32'hB2,       0, 0});
    v.push_back('{0, 0, 0, 0, 1, 1, 32'hA1,       0, 1, 2, 32'hB2,        0, 1, 1, 0,    1, 2, 32'hB2,       0, 0});
    v.push_back('{0, 0, 0, 0, 1, 1, 32'hA1,       0, 1, 2, 32'hB2,        1, 0, 1, 0,    1, 2, 32'hB2,       0, 0});
    v.push_back('{0, 0, 0, 0, 1, 1, 32'hA1,       0, 1, 2, 32'hB2,        0, 1, 1, 0,    1, 1, 32'hA1,       0, 0});
    v.push_back('{0, 0, 0, 0, 1, 1, 32'hA1,       0, 1, 2, 32'hB2,        0, 1, 1, 0,    1, 2, 32'hB2,       0, 0});
    v.push_back('{0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,         0, 0, 1, 0,    1, 2, 32'hB2,       0, 0});
    v.push_back('{0, 0, 0, 0, 0, 0, 32'h0,        0, 1, 0, 32'hFFFFFFFF,  0, 1, 1, 0,    0, 0, 32'h0,        0, 0});
    v.push_back('{0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,         0, 0, 1, 0,    0, 0, 32'h0,        0, 0});
    v.push_back('{1, 7, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,         0, 0, 1, 0,    0, 0, 32'h0,        0, 0});
    v.push_back('{1, 7, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,         0, 0, 1, 0,    0, 0, 32'h0,        0, 0});
    v.push_back('{1, 7, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,         0, 0, 1, 0,    0, 0, 32'h0,        0, 0});
    v.push_back('{1, 7, 7, 0, 1, 7, 32'h77,       0, 0, 0, 32'h0,         1, 0, 0, 1,    0, 0, 32'h0,        0, 0});
    v.push_back('{1, 7, 7, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,         0, 0, 1, 1,    1, 7, 32'h77,       0, 0});
    v.push_back('{1, 7, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,         0, 0, 0, 0,    0, 0, 32'h0,        0, 0});
    v.push_back('{1, 3, 3, 0, 1, 3, 32'h0000ABCD, 1, 0, 0, 32'h0,         1, 0, 1, 0,    0, 0, 32'h0,        0, 0});
    v.push_back('{0, 0, 3, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,         0, 0, 1, 1,    1, 3, 32'h0000ABCD, 1, 0});
    v.push_back('{0, 0, 3, 7, 0, 0, 32'h0,        0, 0, 0, 32'h0,         0, 0, 1, 1,    0, 0, 32'h0,        0, 0});

    #12;
    chk("reset_wb_we", -1, 32'(wb_we), 32'h0);
    chk("reset_wb_addr", -1, 32'(wb_addr), 32'h0);
    chk("reset_wb_data", -1, wb_data, 32'h0);
    chk("reset_wb_high", -1, 32'(wb_high), 32'h0);
    @(negedge clk);
    reset = 0;

    foreach (v[i]) begin
      iss_valid = v[i].iv; iss_addr = v[i].ia; rd_addr_a = v[i].ra; rd_addr_b = v[i].rb;
      alu_req = v[i].ar; alu_addr = v[i].aa; alu_data = v[i].ad; alu_high = v[i].ah;
      mem_req = v[i].mr; mem_addr = v[i].ma; mem_data = v[i].md;
      #1;
      chk("alu_gnt", i, 32'(alu_gnt), 32'(v[i].ag));
      chk("mem_gnt", i, 32'(mem_gnt), 32'(v[i].mg));
      chk("iss_ready", i, 32'(iss_ready), 32'(v[i].ir));
      chk("hazard", i, 32'(hazard), 32'(v[i].hz));
      chk("wb_we", i, 32'(wb_we), 32'(v[i].we));
      if (v[i].we) begin
        chk("wb_addr", i, 32'(wb_addr), 32'(v[i].wa));
        chk("wb_data", i, wb_data, v[i].wd);
        chk("wb_high", i, 32'(wb_high), 32'(v[i].wh));
      end
`ifdef REGBANK_WB_BYPASS_EN
      chk("fwd_a_sel", i, 32'(fwd_a_sel), 32'(v[i].fa));
      if (v[i].fa) chk("fwd_data", i, fwd_data, v[i].wd);
`endif
      @(negedge clk);
    end

    // Async reset mid-stream: commit in flight to r7 with counter still nonzero
    iss_valid = 0; rd_addr_a = 7; rd_addr_b = 0; mem_req = 0;
    alu_req = 1; alu_addr = 7; alu_data = 32'h99; alu_high = 0;
    @(negedge clk);
    alu_req = 0;
    #1;
    chk("pre_reset_wb_we", 0, 32'(wb_we), 32'h1);
    chk("pre_reset_hazard", 0, 32'(hazard), 32'h1);
    reset = 1;
    #1;
    chk("async_wb_we", 0, 32'(wb_we), 32'h0);
    chk("async_wb_addr", 0, 32'(wb_addr), 32'h0);
    chk("async_wb_data", 0, wb_data, 32'h0);
    chk("async_hazard", 0, 32'(hazard), 32'h0);
    iss_valid = 1; iss_addr = 7;
    #1;
    chk("async_iss_ready", 0, 32'(iss_ready), 32'h1);
    iss_valid = 0;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    #1;
    chk("post_reset_hazard", 0, 32'(hazard), 32'h0);
    chk("post_reset_wb_we", 0, 32'(wb_we), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regbank_wb_arbiter.md
Name: regbank_wb_arbiter

Overview:
- Owns the single write port of the 16x32 register bank (r0 hardwired to zero).
- Arbitrates that port between the ALU write-back requester and the memory load-return requester.
- Keeps a per-register scoreboard of outstanding writes so the decode stage can stall operand reads on RAW hazards.
- Sits between the execute/memory stages and the register bank write inputs (we, we_high, addr_d, data_d).

Parameters:
- STARVE_LIMIT, 3: max consecutive MEM grants while ALU is waiting before ALU is forced a grant; legal range 1..15.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high
- iss_valid  in  1  decode issues an instruction that will write iss_addr
- iss_addr  in  4  destination register of issued instruction
- iss_ready  out  1  issue accepted (scoreboard counter for iss_addr not saturated)
- rd_addr_a  in  4  operand A register being read by decode
- rd_addr_b  in  4  operand B register being read by decode
- hazard  out  1  operand A or B has an outstanding write; decode must stall
- alu_req  in  1  ALU result valid
- alu_addr  in  4  ALU destination register
- alu_data  in  32  ALU result
- alu_high  in  1  write only upper half: data_d[15:0] goes to bits 31:16
- alu_gnt  out  1  ALU request consumed this cycle
- mem_req  in  1  load data valid
- mem_addr  in  4  load destination register
- mem_data  in  32  load data
- mem_gnt  out  1  MEM request consumed this cycle
- wb_we  out  1  register bank write enable
- wb_high  out  1  register bank upper-half write select
- wb_addr  out  4  register bank write address
- wb_data  out  32  register bank write data

Behaviour:
- Reset (async): all scoreboard counters 0, starve counter 0, wb_we=0, wb_high=0, wb_addr=0, wb_data=0.
- Grants are combinational in the request cycle; the write port outputs are registered, giving 1-cycle latency from grant to wb_we.
- A requester holds req/addr/data stable until it sees gnt. At most one gnt per cycle.
- Arbitration:
  - Only one requesting: that one is granted.
  - Both requesting: MEM wins unless starve_cnt == STARVE_LIMIT, in which case ALU wins.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) when MEM is granted while alu_req=1.
  - Clears to 0 when ALU is granted or alu_req=0.
- Granted write to addr 0: gnt asserted and scoreboard untouched; next cycle wb_we=0.
- Granted write to addr != 0: next cycle wb_we=1 with wb_addr/wb_data/wb_high from the winner. MEM always drives wb_high=0.
- No grant: next cycle wb_we=0; wb_addr/wb_data hold their previous values.
- Scoreboard: one 2-bit counter per register r1..r15.
  - +1 on iss_valid&&iss_ready when iss_addr != 0.
  - -1 when wb_we=1 for that address, i.e. on commit, the cycle after grant.
  - Increment and decrement to the same register in the same cycle: net unchanged.
  - iss_ready=0 when the iss_addr counter == 3 and no decrement to it occurs this cycle. iss_addr=0 is always ready.
  - A decrement of a counter already at 0 (unissued write) is ignored; the counter stays 0.
- hazard = (rd_addr_a != 0 && cnt[rd_addr_a] != 0) || (rd_addr_b != 0 && cnt[rd_addr_b] != 0). Combinational on counter state; the current cycle's issue does not affect it.

Optional Feature:
- Macro: REGBANK_WB_BYPASS_EN.
- When defined:
  - A read register equal to wb_addr while wb_we=1 and counter == 1 is not flagged in hazard.
  - Extra outputs fwd_a_sel/fwd_b_sel (1 bit) and fwd_data (32 bits, = wb_data) let decode forward the committing value.
  - For wb_high writes, fwd is not asserted and hazard stands.
- When undefined: these ports are absent and hazard is exactly as above.

Test Plan:
- Issue r5, then ALU req addr=5 data=0x12345678 -> alu_gnt same cycle; next cycle wb_we=1, wb_addr=5, wb_data=0x12345678. hazard for rd_addr_a=5 is 1 from issue until the cycle after commit, then 0.
- ALU and MEM both requesting continuously, STARVE_LIMIT=3 -> grant pattern MEM,MEM,MEM,ALU, repeating.
- Issue r7 three times -> fourth issue to r7 sees iss_ready=0. Same cycle as a commit to r7 -> iss_ready=1 and counter stays 3.
- MEM req addr=0 data=0xFFFFFFFF -> mem_gnt=1; next cycle wb_we=0; hazard for r0 always 0.
- Assert reset mid-stream with counters nonzero and wb_we=1 -> outputs and counters 0 immediately, without waiting for a clock edge.
- ALU alu_high=1 addr=3 data=0x0000ABCD -> wb_high=1, wb_data[15:0]=0xABCD; with REGBANK_WB_BYPASS_EN, fwd_a_sel=0 for rd_addr_a=3.
